// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding,
// byte width and default gap/timeout settings.
package uart_pkg;
  localparam int UART_DATA_W      = 8;
  localparam int DEF_GAP_CYCLES   = 1;
  localparam int DEF_BUSY_TIMEOUT = 31;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after i_last,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_win,
  output logic             o_any
);
  always_comb begin
    o_win = '0;
    // Walk the ring backwards so the nearest candidate after i_last wins.
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_valid[(int'(i_last) + k) % N_REQ])
        o_win = IW'((int'(i_last) + k) % N_REQ);
    end
  end

  assign o_any = |i_valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among N_REQ byte sources.
// Optional busy-rise watchdog is built in when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_transmit,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [IW-1:0]                grant_id,
  output logic                         active,
  output logic                         timeout_err
);
  arb_state_t             r_state, w_next;
  logic [IW-1:0]          r_last, r_grant, w_win;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_active;
  logic [3:0]             r_gap_cnt;
  logic                   w_any, w_accept, w_release, w_wd_expire;
  arb_state_t             w_after_frame;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_any   (w_any)
  );

  assign w_after_frame = (GAP_CYCLES == 0) ? IDLE : GAP;

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    tx_transmit = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_accept  = 1'b1;
        req_ready = N_REQ'(1) << w_win;
        w_next    = LOAD;
      end
      LOAD: begin
        tx_transmit = 1'b1;
        w_next      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)          w_next = WAIT_DONE;
        else if (w_wd_expire) w_next = w_after_frame;
      end
      WAIT_DONE: if (!tx_busy) w_next = w_after_frame;
      GAP:       if (r_gap_cnt == 4'(GAP_CYCLES - 1)) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  assign w_release = (w_next == IDLE) && (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= IW'(N_REQ - 1);
      r_grant   <= '0;
      r_tx_data <= '0;
      r_active  <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_next;
      // tx_data only moves on accept: the serializer re-reads it whenever idle.
      if (w_accept) begin
        r_tx_data <= req_data[int'(w_win)*UART_DATA_W +: UART_DATA_W];
        r_grant   <= w_win;
        r_last    <= w_win;
        r_active  <= 1'b1;
      end else if (w_release) begin
        r_active  <= 1'b0;
      end
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 4'd1 : 4'd0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_timeout;

  assign w_wd_expire = (r_wd == 8'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= (r_state == WAIT_BUSY) ? r_wd + 8'd1 : 8'd0;
      if (r_state == WAIT_BUSY && !tx_busy && w_wd_expire)
        r_timeout <= 1'b1;
    end
  end

  assign timeout_err = r_timeout;
`else
  // No watchdog: never expires, BUSY_TIMEOUT only sized for the watchdog build.
  assign w_wd_expire = (BUSY_TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  assign tx_data  = r_tx_data;
  assign grant_id = r_grant;
  assign active   = r_active;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural
// serializer and a frame-level round-robin reference model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N    = 4;
  localparam int G    = 2;
  localparam int TO   = 31;
  localparam int IW   = 2;
  localparam int BITS = 11;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    tb_valid, req_valid, req_ready;
  logic [8*N-1:0]  req_data;
  logic            tx_transmit, tx_busy, active, timeout_err;
  logic [7:0]      tx_data;
  logic [IW-1:0]   grant_id;

  assign req_valid = tb_valid & {N{~reset}};
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_transmit(tx_transmit), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  // Serializer model: busy rises one cycle after the strobe falls, 1 bit/cycle.
  logic       stuck = 1'b0, ser_pend, txd;
  logic [10:0] ser_sh;
  logic [3:0]  ser_left;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0; ser_pend <= 1'b0; ser_left <= '0; ser_sh <= '1;
    end else begin
      if (tx_transmit && !stuck) ser_pend <= 1'b1;
      if (ser_pend) begin
        ser_pend <= 1'b0; tx_busy <= 1'b1; ser_left <= 4'(BITS);
      end else if (tx_busy) begin
        ser_left <= ser_left - 4'd1;
        ser_sh   <= {1'b1, ser_sh[10:1]};
        if (ser_left == 4'd1) tx_busy <= 1'b0;
      end
      if (!tx_busy && !ser_pend) ser_sh <= {1'b1, ^tx_data, tx_data, 1'b0};
    end
  end
  assign txd = tx_busy ? ser_sh[0] : 1'b1;

  int tests = 0, fails = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_ref(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct { logic [IW-1:0] id; logic [7:0] b; } exp_t;
  exp_t       sb_q[$];
  exp_t       cur;
  logic [7:0] sent_log[$], exp_log[$];
  logic [7:0] src_q[N][$];
  logic [N-1:0] acc_mask = '0;
  logic [10:0]  frame_bits;
  bit  model_en = 1'b1, frame_open, busy_prev, cur_v;
  int  cyc = 0, earliest, acc_cyc, m_last, nbits;

  // Monitor + reference model: a grant is due whenever no frame is open,
  // the post-frame gap has elapsed and some requester is valid.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_last = N - 1; frame_open = 0; earliest = 0; acc_cyc = -10;
        busy_prev = 0; nbits = 0; cur_v = 0; sb_q.delete(); acc_mask = '0;
        chk("rst_ready", req_ready, 0);  chk("rst_tx", tx_transmit, 0);
        chk("rst_active", active, 0);    chk("rst_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);   chk("rst_err", timeout_err, 0);
      end else if (model_en) begin
        logic [N-1:0] exp_rdy;
        int w;
        exp_t e;
        if (busy_prev && !tx_busy) begin
          frame_open = 0;
          earliest   = cyc + G + 1;
          chk("frame_len", nbits, BITS);
          if (cur_v) chk("frame_bits", frame_bits, {1'b1, ^cur.b, cur.b, 1'b0});
        end
        if (tx_busy) begin
          if (nbits < BITS) frame_bits[nbits] = txd;
          nbits++;
          if (cur_v) chk("tx_data_hold", tx_data, cur.b);
        end
        busy_prev = tx_busy;
        chk("active", active, (cyc > acc_cyc) && (frame_open || cyc < earliest));
        chk("timeout_err", timeout_err, 0);
        exp_rdy = '0;
        if (!frame_open && cyc >= earliest && req_valid != 0) begin
          w = rr_ref(m_last, req_valid);
          exp_rdy = N'(1) << w;
          e.id = IW'(w);
          e.b  = req_data[8*w +: 8];
          sb_q.push_back(e);
          m_last = w; frame_open = 1; acc_cyc = cyc;
        end
        chk("req_ready", req_ready, exp_rdy);
        acc_mask = req_ready;
        chk("tx_transmit", tx_transmit, cyc == acc_cyc + 1);
        if (tx_transmit) begin
          nbits = 0;
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: strobe with no expected byte at cycle %0d", cyc);
          end else begin
            cur = sb_q.pop_front(); cur_v = 1;
            chk("strobe_data", tx_data, cur.b);
            chk("strobe_grant", grant_id, cur.id);
            sent_log.push_back(tx_data);
          end
        end
      end else begin
        acc_mask = req_ready;
      end
    end
  end

  // One cycle of stimulus: retire accepted bytes and present the next queued ones.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) tb_valid[i] = 1'b0;
      if (!tb_valid[i] && src_q[i].size() > 0) begin
        tb_valid[i] = 1'b1;
        req_data[8*i +: 8] = src_q[i].pop_front();
      end
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int k = 0;
    while (k < 3000 && (tb_valid != 0 || active || tx_busy || pending())) begin
      step(); k++;
    end
    repeat (2) step();
    chk("drain_bound", k < 3000, 1);
  endtask

  task automatic check_log(string nm);
    chk({nm, "_len"}, sent_log.size(), exp_log.size());
    for (int i = 0; i < sent_log.size() && i < exp_log.size(); i++)
      chk(nm, sent_log[i], exp_log[i]);
    sent_log.delete(); exp_log.delete();
  endtask

  task automatic wait_busy();
    int k = 0;
    while (k < 200 && !tx_busy) begin step(); k++; end
    chk("busy_rise_bound", tx_busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int r, k;
    tb_valid = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_data", tx_data, 0);
      chk("idle_grant", grant_id, 0);
    end

    // All four requesters: round-robin from requester 0, then wrap.
    sent_log.delete();
    src_q[0].push_back(8'h10); src_q[0].push_back(8'h10);
    src_q[1].push_back(8'h21); src_q[2].push_back(8'h32); src_q[3].push_back(8'h43);
    drain();
    exp_log.push_back(8'h10); exp_log.push_back(8'h21); exp_log.push_back(8'h32);
    exp_log.push_back(8'h43); exp_log.push_back(8'h10);
    check_log("rr_order");

    src_q[0].push_back(8'hA5);
    drain();
    exp_log.push_back(8'hA5);
    check_log("single_a5");

    // Requester 2 alone, requester 1 joins mid-frame and must win next.
    src_q[2].push_back(8'h5A); src_q[2].push_back(8'h6B);
    step(); wait_busy();
    src_q[1].push_back(8'h7C);
    drain();
    exp_log.push_back(8'h5A); exp_log.push_back(8'h7C); exp_log.push_back(8'h6B);
    check_log("late_join");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, N - 1);
        if (src_q[r].size() < 2) src_q[r].push_back(8'($urandom));
      end
      step();
      if ($urandom_range(0, 49) == 0) begin
        r = $urandom_range(0, N - 1);
        tb_valid[r] = 1'b0;
      end
    end
    drain();
    chk("sb_empty_random", sb_q.size(), 0);
    sent_log.delete();

    // Reset in the middle of a frame; pointer must restart at requester 0.
    for (int i = 0; i < N; i++) src_q[i].push_back(8'hB0 + 8'(i));
    step(); wait_busy(); step(); step();
    reset = 1'b1; tb_valid = '0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    step();
    reset = 1'b0;
    sent_log.delete(); exp_log.delete();
    for (int i = N - 1; i >= 0; i--) src_q[i].push_back(8'hD0 + 8'(i));
    drain();
    for (int i = 0; i < N; i++) exp_log.push_back(8'hD0 + 8'(i));
    check_log("post_reset");

`ifdef UART_TX_ARB_TIMEOUT_EN
    model_en = 1'b0; stuck = 1'b1;
    src_q[3].push_back(8'hEE);
    k = 0; while (k < 100 && !tx_transmit) begin step(); k++; end
    chk("to_strobe", tx_transmit, 1);
    k = 0; while (k < 100 && !timeout_err) begin step(); k++; end
    chk("to_latency", k, TO + 1);
    stuck = 1'b0;
    src_q[0].push_back(8'h99);
    k = 0; while (k < 100 && !tx_transmit) begin step(); k++; end
    chk("to_regrant_strobe", tx_transmit, 1);
    chk("to_regrant_data", tx_data, 8'h99);
    drain();
    chk("to_sticky", timeout_err, 1);
`else
    k = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
